jpeg_bit_packer: RTL and testbench

Receives per-symbol Huffman output from the Huffman encoder controller and packs it into a JPEG entropy-coded byte stream. Fields are concatenated MSB-first into a bit accumulator, and whole bytes are emitted over a valid/ready interface with 0xFF→0xFF 0x00 byte stuffing. On flush, the block pads the final byte with 1s and appends the EOI marker 0xFFD9. It sits directly downstream of the encoder controller and feeds the JPEG file writer / output DMA.

---
 rtl/jpeg_pkg.sv | 29 ++
 rtl/huff_field_concat.sv | 34 +++
 rtl/jpeg_bit_packer.sv | 196 +++++++++++++++++++
 tb/tb_jpeg_bit_packer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared constants, state encoding and field helpers for the JPEG bit packer.
package jpeg_pkg;

  localparam int ACC_W_DEF = 64;
  localparam int EV_W      = 41;

  localparam logic [15:0] MARKER_EOI = 16'hFFD9;
  localparam logic [7:0]  STUFF_BYTE = 8'h00;

  localparam int DC_LEN_MAX  = 9;
  localparam int DC_SIZE_MAX = 8;
  localparam int AC_LEN_MAX  = 16;
  localparam int AC_SIZE_MAX = 8;

  typedef enum logic [2:0] {IDLE, RUN, STUFF, PAD, EOI_FF, EOI_D9, DONE} state_e;

  // Clamp an 8-bit length to its field limit.
  function automatic logic [4:0] sat_len(input logic [7:0] len, input logic [4:0] lim);
    return (len > {3'b000, lim}) ? lim : len[4:0];
  endfunction

  // Keep only the low 'len' bits of a field (len may be 0..16).
  function automatic logic [15:0] mask_field(input logic [15:0] v, input logic [4:0] len);
    logic [16:0] m;
    m = (17'd1 << len) - 17'd1;
    return v & m[15:0];
  endfunction

endpackage

// File: rtl/huff_field_concat.sv
// Concatenates one symbol's Huffman/amplitude fields MSB-first into an LSB-aligned word.
module huff_field_concat
  import jpeg_pkg::*;
(
  input  logic            block_first_i,
  input  logic [8:0]      dc_code_i,
  input  logic [7:0]      dc_len_i,
  input  logic [7:0]      dc_amp_i,
  input  logic [7:0]      dc_size_i,
  input  logic [15:0]     ac_code_i,
  input  logic [7:0]      ac_len_i,
  input  logic [7:0]      ac_amp_i,
  input  logic [7:0]      ac_size_i,
  output logic [EV_W-1:0] bits_o,
  output logic [5:0]      n_o
);

  logic [4:0] dc_l, dc_s, ac_l, ac_s;

  // DC fields only lead the first symbol of a block; each field shifts in after the previous one.
  always_comb begin
    dc_l   = block_first_i ? sat_len(dc_len_i,  5'(DC_LEN_MAX))  : 5'd0;
    dc_s   = block_first_i ? sat_len(dc_size_i, 5'(DC_SIZE_MAX)) : 5'd0;
    ac_l   = sat_len(ac_len_i,  5'(AC_LEN_MAX));
    ac_s   = sat_len(ac_size_i, 5'(AC_SIZE_MAX));
    bits_o = '0;
    bits_o = (bits_o << dc_l) | EV_W'(mask_field({7'b0, dc_code_i}, dc_l));
    bits_o = (bits_o << dc_s) | EV_W'(mask_field({8'b0, dc_amp_i},  dc_s));
    bits_o = (bits_o << ac_l) | EV_W'(mask_field(ac_code_i,         ac_l));
    bits_o = (bits_o << ac_s) | EV_W'(mask_field({8'b0, ac_amp_i},  ac_s));
    n_o    = 6'(dc_l) + 6'(dc_s) + 6'(ac_l) + 6'(ac_s);
  end

endmodule

// File: rtl/jpeg_bit_packer.sv
// Packs Huffman symbols into a byte-stuffed JPEG entropy stream terminated by EOI.
module jpeg_bit_packer
  import jpeg_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        jpeg_out_enable,
  input  logic        jpeg_out_end,
  input  logic [8:0]  jpeg_dc_out,
  input  logic [7:0]  jpeg_dc_out_length,
  input  logic [7:0]  jpeg_dc_code_list,
  input  logic [7:0]  jpeg_dc_code_size,
  input  logic [15:0] huffman_code,
  input  logic [7:0]  huffman_code_length,
  input  logic [7:0]  code_out,
  input  logic [7:0]  code_size_out,
  input  logic        flush,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  localparam int FW = $clog2(ACC_W + 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [FW-1:0]    fill_q, fill_d, fill_add, fill_sub;
  logic             bf_q, bf_d;      // next event starts a block (carries DC)
  logic             fp_q, fp_d;      // flush requested, EOI not yet started
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             ov_q, ov_d;      // output register holds a byte
  logic [7:0]       ob_q, ob_d;

  logic [EV_W-1:0]  ev_bits;
  logic [5:0]       ev_n;
  logic             out_free, ev_state_ok, ev_fit, ev_acc, load;
  logic [7:0]       load_byte, top_byte, pad_byte;

  huff_field_concat u_concat (
    .block_first_i (bf_q),
    .dc_code_i     (jpeg_dc_out),
    .dc_len_i      (jpeg_dc_out_length),
    .dc_amp_i      (jpeg_dc_code_list),
    .dc_size_i     (jpeg_dc_code_size),
    .ac_code_i     (huffman_code),
    .ac_len_i      (huffman_code_length),
    .ac_amp_i      (code_out),
    .ac_size_i     (code_size_out),
    .bits_o        (ev_bits),
    .n_o           (ev_n)
  );

  // Valid bits live in acc_q[fill_q-1:0]; the oldest bit is the highest one.
  assign top_byte = 8'(acc_q >> (fill_q - FW'(8)));
  assign pad_byte = 8'(acc_q << (FW'(8) - fill_q)) | (8'hFF >> fill_q);

  // Next-state: append the event, move at most one byte into the output register.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    bf_d      = bf_q;
    fp_d      = fp_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    fill_add  = '0;
    fill_sub  = '0;
    load      = 1'b0;
    load_byte = 8'h00;

    out_free    = !ov_q || out_ready;
    ev_state_ok = (state_q == IDLE) || (state_q == RUN);
    ev_fit      = (32'(fill_q) + 32'(ev_n)) <= 32'(ACC_W);
    ev_acc      = jpeg_out_enable && ev_state_ok && ev_fit;

    if (ev_acc) begin
      acc_d    = (acc_q << ev_n) | ACC_W'(ev_bits);
      fill_add = FW'(ev_n);
      bf_d     = jpeg_out_end;
    end else if (jpeg_out_enable) begin
      ovf_d = 1'b1;
    end

    if (flush && ev_state_ok) fp_d = 1'b1;

    case (state_q)
      IDLE, RUN: begin
        if (ev_acc) state_d = RUN;
        if (fill_q >= FW'(8)) begin
          if (out_free) begin
            load      = 1'b1;
            load_byte = top_byte;
            fill_sub  = FW'(8);
            if (top_byte == 8'hFF) state_d = STUFF;
          end
        end else if (fp_q && !ev_acc) begin
          // Tail bits are padded first; an empty accumulator goes straight to the marker.
          if (fill_q != '0) begin
            state_d = PAD;
          end else begin
            state_d = EOI_FF;
            fp_d    = 1'b0;
          end
        end
      end
      STUFF: begin
        if (out_free) begin
          load      = 1'b1;
          load_byte = STUFF_BYTE;
          state_d   = RUN;
        end
      end
      PAD: begin
        if (out_free) begin
          load      = 1'b1;
          load_byte = pad_byte;
          fill_sub  = fill_q;
          // A padded 0xFF still owes its stuff byte; RUN then starts the marker.
          if (pad_byte == 8'hFF) begin
            state_d = STUFF;
          end else begin
            state_d = EOI_FF;
            fp_d    = 1'b0;
          end
        end
      end
      EOI_FF: begin
        if (out_free) begin
          load      = 1'b1;
          load_byte = MARKER_EOI[15:8];
          state_d   = EOI_D9;
        end
      end
      EOI_D9: begin
        if (out_free) begin
          load      = 1'b1;
          load_byte = MARKER_EOI[7:0];
          state_d   = DONE;
        end
      end
      DONE: begin
        if (ov_q && out_ready) begin
          done_d  = 1'b1;
          bf_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    fill_d = fill_q + fill_add - fill_sub;
    ov_d   = ov_q && !out_ready;
    ob_d   = ob_q;
    if (load) begin
      ov_d = 1'b1;
      ob_d = load_byte;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      fill_q  <= '0;
      bf_q    <= 1'b1;
      fp_q    <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      ov_q    <= 1'b0;
      ob_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      bf_q    <= bf_d;
      fp_q    <= fp_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      ov_q    <= ov_d;
      ob_q    <= ob_d;
    end
  end

  assign out_byte  = ob_q;
  assign out_valid = ov_q;
  assign done      = done_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q != IDLE) || (fill_q != '0);

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// Scoreboard bench: a bit-queue reference model predicts the byte stream, a monitor checks it.
module tb_jpeg_bit_packer;

  logic        clock = 1'b0;
  logic        reset;
  logic        jpeg_out_enable, jpeg_out_end, flush, out_ready;
  logic [8:0]  jpeg_dc_out;
  logic [7:0]  jpeg_dc_out_length, jpeg_dc_code_list, jpeg_dc_code_size;
  logic [15:0] huffman_code;
  logic [7:0]  huffman_code_length, code_out, code_size_out;
  logic [7:0]  out_byte;
  logic        out_valid, busy, done, overflow;

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  bit   rand_rdy = 0;
  logic bf_m = 1'b1;
  logic [7:0] exp_q[$];
  logic       bitq[$];

  always #5 clock = ~clock;

  jpeg_bit_packer #(.ACC_W(64)) dut (
    .clock(clock), .reset(reset),
    .jpeg_out_enable(jpeg_out_enable), .jpeg_out_end(jpeg_out_end),
    .jpeg_dc_out(jpeg_dc_out), .jpeg_dc_out_length(jpeg_dc_out_length),
    .jpeg_dc_code_list(jpeg_dc_code_list), .jpeg_dc_code_size(jpeg_dc_code_size),
    .huffman_code(huffman_code), .huffman_code_length(huffman_code_length),
    .code_out(code_out), .code_size_out(code_size_out),
    .flush(flush), .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .overflow(overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void mpush(input logic [15:0] v, input int len, input int lim);
    int l;
    l = (len > lim) ? lim : len;
    for (int i = l - 1; i >= 0; i--) bitq.push_back(v[i]);
  endfunction

  function automatic void mbytes();
    while (bitq.size() >= 8) begin
      logic [7:0] b;
      b = 8'h00;
      for (int i = 0; i < 8; i++) b = {b[6:0], bitq.pop_front()};
      exp_q.push_back(b);
      if (b == 8'hFF) exp_q.push_back(8'h00);
    end
  endfunction

  function automatic void mflush();
    if (bitq.size() > 0) begin
      while (bitq.size() < 8) bitq.push_back(1'b1);
      mbytes();
    end
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hD9);
    bf_m = 1'b1;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic pv, pr, prst;
    logic [7:0] pb;
    pv = 1'b0; pr = 1'b0; prst = 1'b1; pb = 8'h00;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (pv && !pr && !prst)
          chk("stall_hold", 32'({out_valid, out_byte}), 32'({1'b1, pb}));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_byte: got %0h, expected none", out_byte);
          end else begin
            chk("stream_byte", 32'(out_byte), 32'(exp_q.pop_front()));
          end
        end
        if (done) done_cnt++;
      end
      pv = out_valid; pr = out_ready; pb = out_byte; prst = reset;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic clr_in();
    jpeg_out_enable = 0; jpeg_out_end = 0; flush = 0;
    jpeg_dc_out = '0; jpeg_dc_out_length = '0; jpeg_dc_code_list = '0; jpeg_dc_code_size = '0;
    huffman_code = '0; huffman_code_length = '0; code_out = '0; code_size_out = '0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin tick(); n++; end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d bytes outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic ev(input logic [8:0] dc, input int dcl, input logic [7:0] dca, input int dcs,
                    input logic [15:0] hc, input int hcl, input logic [7:0] ca, input int cs,
                    input logic e, input bit gate, input bit keep);
    if (gate) wait_empty();
    jpeg_dc_out = dc;   jpeg_dc_out_length = 8'(dcl);
    jpeg_dc_code_list = dca; jpeg_dc_code_size = 8'(dcs);
    huffman_code = hc;  huffman_code_length = 8'(hcl);
    code_out = ca;      code_size_out = 8'(cs);
    jpeg_out_enable = 1; jpeg_out_end = e;
    if (keep) begin
      if (bf_m) begin
        mpush({7'b0, dc}, dcl, 9);
        mpush({8'b0, dca}, dcs, 8);
      end
      mpush(hc, hcl, 16);
      mpush({8'b0, ca}, cs, 8);
      mbytes();
      bf_m = e;
    end
    tick();
    clr_in();
  endtask

  task automatic fl(input bit gate);
    if (gate) wait_empty();
    mflush();
    flush = 1;
    tick();
    flush = 0;
  endtask

  task automatic wait_done();
    int d0, n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 600) begin tick(); n++; end
    repeat (3) tick();
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1; out_ready = 0; clr_in();
    tick(); tick();
    reset = 0; out_ready = 1;
    bitq.delete(); exp_q.delete(); bf_m = 1'b1;
    tick();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    clr_in();
    reset = 1; out_ready = 1;
    repeat (3) tick();
    chk("rst_valid",    32'(out_valid), 32'd0);
    chk("rst_byte",     32'(out_byte),  32'd0);
    chk("rst_busy",     32'(busy),      32'd0);
    chk("rst_done",     32'(done),      32'd0);
    chk("rst_overflow", 32'(overflow),  32'd0);
    reset = 0;
    tick();

    // single block: 56 FF 00 FF D9
    ev(9'b010, 3, 8'b101, 3, 16'b1011, 4, 8'h1, 1, 1'b1, 1, 1);
    fl(0);
    wait_done();

    // block boundaries: DC only on the first symbol of each block
    ev(9'h1A5, 9, 8'h3C, 6, 16'h00F2, 8, 8'h05, 3, 1'b1, 1, 1);
    ev(9'h003, 2, 8'h01, 1, 16'h000D, 5, 8'h07, 3, 1'b0, 1, 1);
    ev(9'h1FF, 9, 8'hFF, 8, 16'h0002, 3, 8'h00, 0, 1'b0, 1, 1);
    ev(9'h0AA, 8, 8'h55, 7, 16'h0031, 6, 8'h02, 2, 1'b1, 1, 1);
    ev(9'h015, 5, 8'h09, 4, 16'h0003, 2, 8'h01, 1, 1'b1, 1, 1);
    fl(1);
    wait_done();

    // stuffing: FF 00 FF 00 FF D9
    ev(9'h000, 0, 8'h00, 0, 16'hFFFF, 16, 8'h00, 0, 1'b0, 1, 1);
    fl(1);
    wait_done();

    // backpressure mid-stream
    out_ready = 0;
    ev(9'b010, 3, 8'b101, 3, 16'b1011, 4, 8'h1, 1, 1'b1, 0, 1);
    fl(0);
    repeat (20) tick();
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_byte",  32'(out_byte),  32'h56);
    out_ready = 1;
    wait_done();

    // overflow: fifth 16-bit event is dropped
    do_reset();
    out_ready = 0;
    ev(9'h000, 0, 8'h00, 0, 16'h1234, 16, 8'h00, 0, 1'b0, 0, 1);
    ev(9'h000, 0, 8'h00, 0, 16'h5678, 16, 8'h00, 0, 1'b0, 0, 1);
    ev(9'h000, 0, 8'h00, 0, 16'h9ABC, 16, 8'h00, 0, 1'b0, 0, 1);
    ev(9'h000, 0, 8'h00, 0, 16'hDEF0, 16, 8'h00, 0, 1'b0, 0, 1);
    chk("ovf_before", 32'(overflow), 32'd0);
    ev(9'h000, 0, 8'h00, 0, 16'hAAAA, 16, 8'h00, 0, 1'b0, 0, 0);
    chk("ovf_after",  32'(overflow), 32'd1);
    out_ready = 1;
    fl(1);
    wait_done();
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // randomized traffic with random backpressure
    do_reset();
    rand_rdy = 1;
    for (int i = 0; i < 120; i++) begin
      ev(9'($urandom), $urandom_range(0, 11), 8'($urandom), $urandom_range(0, 10),
         16'($urandom), $urandom_range(0, 20), 8'($urandom), $urandom_range(0, 10),
         1'($urandom_range(0, 3) == 0), 1, 1);
      if ($urandom_range(0, 9) == 0) begin
        fl(1);
        wait_done();
      end
    end
    fl(1);
    wait_done();
    chk("rand_overflow", 32'(overflow), 32'd0);
    rand_rdy = 0;
    out_ready = 1;

    // reset while a stuff byte is owed
    do_reset();
    ev(9'h000, 0, 8'h00, 0, 16'h00FF, 8, 8'h00, 0, 1'b0, 1, 0);
    exp_q.push_back(8'hFF);
    begin
      int n;
      n = 0;
      while (!(out_valid && out_byte == 8'hFF) && n < 50) begin tick(); n++; end
    end
    tick();
    reset = 1; out_ready = 0;
    tick();
    chk("stuffrst_valid",    32'(out_valid), 32'd0);
    chk("stuffrst_byte",     32'(out_byte),  32'd0);
    chk("stuffrst_busy",     32'(busy),      32'd0);
    chk("stuffrst_done",     32'(done),      32'd0);
    chk("stuffrst_overflow", 32'(overflow),  32'd0);
    chk("stuffrst_ff_seen",  32'(exp_q.size()), 32'd0);
    reset = 0; out_ready = 1;
    bitq.delete(); exp_q.delete(); bf_m = 1'b1;
    tick();
    fl(1);
    wait_done();

    chk("final_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
